game_scroll_ctrl: RTL and testbench

GAME_SCROLL_CTRL -- requirements
Module: game_scroll_ctrl

---
 rtl/game_scroll_ctrl_pkg.sv | 18 +
 rtl/game_scroll_ctrl_frame_tick.sv | 32 +++
 rtl/game_scroll_ctrl.sv | 120 ++++++++++++
 tb/tb_game_scroll_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_scroll_ctrl_pkg.sv
// Shared game definitions: state encodings and the playfield constants.
// The ground scroller and sprite blocks import these as well.
package game_scroll_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_RUSH = 2'b10,
        ST_DEAD = 2'b11
    } game_state_e;

    localparam logic [9:0]  V_TRIG     = 10'd480;
    localparam logic [7:0]  PERIOD     = 8'd160;
    localparam logic [3:0]  SPEED_INIT = 4'd6;
    localparam logic [3:0]  SPEED_MAX  = 4'd12;
    localparam logic [13:0] SCORE_MAX  = 14'd9999;

endpackage

// File: rtl/game_scroll_ctrl_frame_tick.sv
// Frame-tick detector: compares the raster position against the trigger
// point and emits a registered one-cycle pulse on the first matching cycle.
module frame_tick #(
    parameter logic [9:0] V_TRIG = 10'd480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_cnt_i,
    input  logic [9:0] v_cnt_i,
    output logic       tick_o
);

    logic match;
    logic match_q;
    logic tick_q;

    assign match = (h_cnt_i == 10'd0) && (v_cnt_i == V_TRIG);

    // Remember the previous match so a held match yields a single pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            match_q <= match;
            tick_q  <= match && !match_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/game_scroll_ctrl.sv
// Game scroll controller: game state machine, per-frame ground scrolling,
// speed ramp every 256 frames and a score that advances every 8 frames.
// Handshake: start and collide are plain level inputs sampled on the clock;
// start acts as a one-cycle request, collide only counts in a new_frame cycle.
module game_scroll_ctrl #(
    parameter logic [9:0] V_TRIG     = game_scroll_ctrl_pkg::V_TRIG,
    parameter logic [7:0] PERIOD     = game_scroll_ctrl_pkg::PERIOD,
    parameter logic [3:0] SPEED_INIT = game_scroll_ctrl_pkg::SPEED_INIT,
    parameter logic [3:0] SPEED_MAX  = game_scroll_ctrl_pkg::SPEED_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        start,
    input  logic        collide,
    output logic [1:0]  state,
    output logic        new_frame,
    output logic [3:0]  speed,
    output logic [7:0]  ground_pos,
    output logic [13:0] score
);

    import game_scroll_ctrl_pkg::*;

    game_state_e state_q, state_d;
    logic [3:0]  speed_q, speed_d;
    logic [7:0]  ground_pos_q, ground_pos_d;
    logic [13:0] score_q, score_d;
    logic [7:0]  frame_q, frame_d;
    logic [2:0]  sub_q, sub_d;
    logic [8:0]  sum9;
    logic        tick;

    frame_tick #(
        .V_TRIG (V_TRIG)
    ) u_frame_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .h_cnt_i (h_cnt),
        .v_cnt_i (v_cnt),
        .tick_o  (tick)
    );

    // Next-state and datapath updates; collide on a tick pre-empts scrolling.
    always_comb begin
        state_d      = state_q;
        speed_d      = speed_q;
        ground_pos_d = ground_pos_q;
        score_d      = score_q;
        frame_d      = frame_q;
        sub_d        = sub_q;
        sum9         = {1'b0, ground_pos_q} + {5'd0, speed_q};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    speed_d = SPEED_INIT;
                    score_d = 14'd0;
                    frame_d = 8'd0;
                    sub_d   = 3'd0;
                end
            end
            ST_RUN, ST_RUSH: begin
                if (tick) begin
                    if (collide) begin
                        state_d = ST_DEAD;
                    end else begin
                        // Low 8 bits of the wrapped sum are exact modulo 256.
                        ground_pos_d = (sum9 < {1'b0, PERIOD}) ? sum9[7:0]
                                                               : sum9[7:0] - PERIOD;
                        frame_d = frame_q + 8'd1;
                        if (frame_q == 8'hFF) begin
                            speed_d = (speed_q < SPEED_MAX) ? speed_q + 4'd1 : SPEED_MAX;
                        end
                        sub_d = sub_q + 3'd1;
                        if (sub_q == 3'd7) begin
                            score_d = (score_q < SCORE_MAX) ? score_q + 14'd1 : SCORE_MAX;
                        end
                        if ((state_q == ST_RUN) && (speed_d == SPEED_MAX)) begin
                            state_d = ST_RUSH;
                        end
                    end
                end
            end
            ST_DEAD: begin
                if (start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register all game state; reset is asynchronous so it acts mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            speed_q      <= SPEED_INIT;
            ground_pos_q <= 8'd0;
            score_q      <= 14'd0;
            frame_q      <= 8'd0;
            sub_q        <= 3'd0;
        end else begin
            state_q      <= state_d;
            speed_q      <= speed_d;
            ground_pos_q <= ground_pos_d;
            score_q      <= score_d;
            frame_q      <= frame_d;
            sub_q        <= sub_d;
        end
    end

    assign state      = state_q;
    assign new_frame  = tick;
    assign speed      = speed_q;
    assign ground_pos = ground_pos_q;
    assign score      = score_q;

endmodule

// File: tb/tb_game_scroll_ctrl.sv
// Testbench for game_scroll_ctrl: directed scenarios plus a randomized run,
// all checked against a frame-level game model kept in this file.
module tb_game_scroll_ctrl;

    localparam int V_TRIG     = 480;
    localparam int PERIOD     = 160;
    localparam int SPEED_INIT = 6;
    localparam int SPEED_MAX  = 12;
    localparam int SCORE_MAX  = 9999;
    localparam int M_IDLE = 0, M_RUN = 1, M_RUSH = 2, M_DEAD = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt, v_cnt;
    logic        start, collide;
    logic [1:0]  state;
    logic        new_frame;
    logic [3:0]  speed;
    logic [7:0]  ground_pos;
    logic [13:0] score;
    logic [27:0] act;

    int checks = 0;
    int failures = 0;
    int m_state, m_spd, m_gp, m_score, m_frame, m_sub;
    logic [27:0] exp_q[$];

    game_scroll_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .start      (start),
        .collide    (collide),
        .state      (state),
        .new_frame  (new_frame),
        .speed      (speed),
        .ground_pos (ground_pos),
        .score      (score)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    assign act = {state, speed, ground_pos, score};

    // ---------------- reference model ----------------
    function automatic logic [27:0] exp_vec();
        exp_vec = {2'(m_state), 4'(m_spd), 8'(m_gp), 14'(m_score)};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_spd = SPEED_INIT; m_gp = 0;
        m_score = 0; m_frame = 0; m_sub = 0;
    endtask

    task automatic model_start();
        if (m_state == M_IDLE) begin
            m_state = M_RUN; m_spd = SPEED_INIT; m_score = 0; m_frame = 0; m_sub = 0;
        end else if (m_state == M_DEAD) begin
            m_state = M_IDLE;
        end
    endtask

    task automatic model_tick(input bit c, input bit s);
        if (m_state == M_RUN || m_state == M_RUSH) begin
            if (c) begin
                m_state = M_DEAD;
            end else begin
                m_gp    = (m_gp + m_spd) % PERIOD;
                m_frame = (m_frame + 1) % 256;
                if (m_frame == 0) m_spd = (m_spd + 1 > SPEED_MAX) ? SPEED_MAX : m_spd + 1;
                m_sub = (m_sub + 1) % 8;
                if (m_sub == 0) m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
                if (m_state == M_RUN && m_spd == SPEED_MAX) m_state = M_RUSH;
            end
        end else if (s) begin
            model_start();
        end
    endtask

    // ---------------- drivers ----------------
    task automatic apply_reset();
        rst_n = 1'b0; h_cnt = 10'd1; v_cnt = 10'd0; start = 1'b0; collide = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One frame: match cycle, then the new_frame cycle carrying c/s.
    task automatic do_frame(input bit c, input bit s);
        @(negedge clk);
        h_cnt = 10'd0; v_cnt = 10'(V_TRIG); collide = 1'b0; start = 1'b0;
        @(negedge clk);
        h_cnt = 10'd1; collide = c; start = s;
        @(negedge clk);
        collide = 1'b0; start = 1'b0;
        model_tick(c, s);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        h_cnt = 10'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_start();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if (act !== {2'b00, 4'd6, 8'd0, 14'd0} || new_frame !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got %h nf=%b expected %h nf=0", act, new_frame,
                     {2'b00, 4'd6, 8'd0, 14'd0});
        end
        do_frame(1'b0, 1'b0);
        checks++;
        if (act !== exp_vec()) begin
            failures++;
            $display("FAIL idle_hold: got %h expected %h", act, exp_vec());
        end
    endtask

    task automatic test_frame_tick();
        @(negedge clk);
        h_cnt = 10'd0; v_cnt = 10'(V_TRIG);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (new_frame !== (i == 0)) begin
                failures++;
                $display("FAIL tick_held cycle %0d: got %b expected %b", i, new_frame, (i == 0));
            end
        end
        h_cnt = 10'd1;
        @(negedge clk);
        h_cnt = 10'd0; v_cnt = 10'(V_TRIG - 1);
        @(negedge clk);
        checks++;
        if (new_frame !== 1'b0) begin
            failures++;
            $display("FAIL tick_wrong_line: got %b expected 0", new_frame);
        end
        h_cnt = 10'd1;
        @(negedge clk);
    endtask

    task automatic test_start_run();
        pulse_start();
        checks++;
        if (act !== {2'b01, 4'd6, 8'd0, 14'd0}) begin
            failures++;
            $display("FAIL start_to_run: got %h expected %h", act, {2'b01, 4'd6, 8'd0, 14'd0});
        end
        repeat (10) do_frame(1'b0, 1'b0);
        checks++;
        if (act !== {2'b01, 4'd6, 8'd60, 14'd1} || act !== exp_vec()) begin
            failures++;
            $display("FAIL ten_frames: got %h expected %h", act, {2'b01, 4'd6, 8'd60, 14'd1});
        end
    endtask

    task automatic test_scroll_wrap();
        repeat (16) do_frame(1'b0, 1'b0);
        checks++;
        if (ground_pos !== 8'd156) begin
            failures++;
            $display("FAIL pos_156: got %0d expected 156", ground_pos);
        end
        do_frame(1'b0, 1'b0);
        checks++;
        if (ground_pos !== 8'd2 || act !== exp_vec()) begin
            failures++;
            $display("FAIL wrap_speed6: got %h expected %h", act, exp_vec());
        end
    endtask

    task automatic test_collide();
        int pre_gp, pre_score;
        // collide high around, but not in, the new_frame cycle
        @(negedge clk); collide = 1'b1; h_cnt = 10'd3;
        @(negedge clk);
        @(negedge clk); h_cnt = 10'd0; v_cnt = 10'(V_TRIG);
        @(negedge clk); h_cnt = 10'd1; collide = 1'b0;
        @(negedge clk);
        model_tick(1'b0, 1'b0);
        checks++;
        if (act !== exp_vec() || state !== 2'b01) begin
            failures++;
            $display("FAIL collide_off_tick: got %h expected %h", act, exp_vec());
        end
        pre_gp = m_gp; pre_score = m_score;
        do_frame(1'b1, 1'b1);
        checks++;
        if (state !== 2'b11 || ground_pos !== 8'(pre_gp) || score !== 14'(pre_score)) begin
            failures++;
            $display("FAIL collide_start_tick: got st=%b pos=%0d sc=%0d expected st=11 pos=%0d sc=%0d",
                     state, ground_pos, score, pre_gp, pre_score);
        end
    endtask

    task automatic test_speed_ramp();
        int exp_s;
        pulse_start();
        checks++;
        if (act !== exp_vec() || state !== 2'b00) begin
            failures++;
            $display("FAIL dead_to_idle: got %h expected %h", act, exp_vec());
        end
        pulse_start();
        for (int f = 1; f <= 1792; f++) begin
            do_frame(1'b0, 1'b0);
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL ramp_frame %0d: got %h expected %h", f, act, exp_vec());
            end
            if (f % 256 == 0) begin
                exp_s = (SPEED_INIT + f / 256 > SPEED_MAX) ? SPEED_MAX : SPEED_INIT + f / 256;
                checks++;
                if (speed !== 4'(exp_s)) begin
                    failures++;
                    $display("FAIL ramp_speed frame %0d: got %0d expected %0d", f, speed, exp_s);
                end
            end
            if (f == 1535 || f == 1536) begin
                checks++;
                if (state !== ((f == 1536) ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL rush_entry frame %0d: got %b expected %b", f, state,
                             ((f == 1536) ? 2'b10 : 2'b01));
                end
            end
        end
        // place the ground at 150 while rushing, then one frame at speed 12
        @(negedge clk);
        force dut.ground_pos_q = 8'd150;
        @(posedge clk);
        #1 release dut.ground_pos_q;
        m_gp = 150;
        do_frame(1'b0, 1'b0);
        checks++;
        if (ground_pos !== 8'd2 || act !== exp_vec()) begin
            failures++;
            $display("FAIL wrap_speed12: got %h expected %h", act, exp_vec());
        end
    endtask

    task automatic test_score_sat();
        @(negedge clk);
        force dut.score_q = 14'd9998;
        @(posedge clk);
        #1 release dut.score_q;
        m_score = 9998;
        for (int f = 0; f < 16; f++) begin
            do_frame(1'b0, 1'b0);
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL score_frame %0d: got %h expected %h", f, act, exp_vec());
            end
        end
        checks++;
        if (score !== 14'd9999) begin
            failures++;
            $display("FAIL score_sat: got %0d expected 9999", score);
        end
        do_frame(1'b1, 1'b0);
        pulse_start();
        checks++;
        if (act !== {2'b00, 4'd12, 8'(m_gp), 14'd9999}) begin
            failures++;
            $display("FAIL idle_holds_score: got %h expected %h", act, {2'b00, 4'd12, 8'(m_gp), 14'd9999});
        end
        pulse_start();
        checks++;
        if (state !== 2'b01 || score !== 14'd0 || speed !== 4'd6) begin
            failures++;
            $display("FAIL restart_clears: got st=%b sc=%0d sp=%0d expected st=01 sc=0 sp=6",
                     state, score, speed);
        end
    endtask

    task automatic test_async_reset();
        repeat (5) do_frame(1'b0, 1'b0);
        @(posedge clk);
        #2;
        h_cnt = 10'd5; v_cnt = 10'(V_TRIG);
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (act !== {2'b00, 4'd6, 8'd0, 14'd0} || new_frame !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got %h nf=%b expected %h nf=0", act, new_frame,
                     {2'b00, 4'd6, 8'd0, 14'd0});
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (new_frame !== 1'b0 || state !== 2'b00) begin
                failures++;
                $display("FAIL post_reset cycle %0d: got nf=%b st=%b expected nf=0 st=00", i, new_frame, state);
            end
        end
        pulse_start();
        do_frame(1'b0, 1'b0);
        checks++;
        if (act !== exp_vec()) begin
            failures++;
            $display("FAIL run_after_reset: got %h expected %h", act, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [27:0] e;
        for (int i = 0; i < 300; i++) begin
            // noise between frames: collide and raster values off the trigger
            @(negedge clk);
            collide = 1'($urandom_range(0, 1));
            h_cnt = 10'($urandom_range(1, 799));
            v_cnt = 10'($urandom_range(0, 1023));
            @(negedge clk);
            collide = 1'b0;
            if ($urandom_range(0, 7) == 0) pulse_start();
            do_frame(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
            exp_q.push_back(exp_vec());
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL random_frame %0d: got %h expected %h", i, act, e);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_frame_tick();
        test_start_run();
        test_scroll_wrap();
        test_collide();
        test_speed_ramp();
        test_score_sat();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
